// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/two_bit_cmp_slice.sv
// One 2-bit magnitude compare step, chained MSB-first through eq/gt.
module two_bit_cmp_slice (
    input  logic [1:0] a2,
    input  logic [1:0] b2,
    input  logic       eq_i,
    input  logic       gt_i,
    output logic       eq_o,
    output logic       gt_o
);

    assign eq_o = eq_i & (a2 == b2);
    assign gt_o = gt_i | (eq_i & (a2 > b2));

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Sequential S-bit unsigned comparator reusing one 2-bit slice,
// MSB pair first, stopping at the first unequal pair.
module serial_cmp_ctrl #(
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         EQ,
    output logic         GT,
    output logic         busy
);

    import cmp_pkg::*;

    localparam int N  = S / 2;
    localparam int IW = idx_w(N);

    cmp_state_t state;
    cmp_state_t state_nx;

    logic [S-1:0]  a_l;
    logic [S-1:0]  b_l;
    logic [IW-1:0] idx;
    logic          eq_acc;
    logic          gt_acc;
    logic          eq_o;
    logic          gt_o;
    logic [1:0]    a2;
    logic [1:0]    b2;
    logic          last;
    logic          res_valid_q;
    logic          eq_q;
    logic          gt_q;

    assign a2   = a_l[2*idx +: 2];
    assign b2   = b_l[2*idx +: 2];
    assign last = !eq_o || (idx == '0);

    two_bit_cmp_slice u_slice (
        .a2   (a2),
        .b2   (b2),
        .eq_i (eq_acc),
        .gt_i (gt_acc),
        .eq_o (eq_o),
        .gt_o (gt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_valid) state_nx = RUN;
            RUN:  if (last)        state_nx = DONE;
            DONE: if (res_ready)   state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_l         <= '0;
            b_l         <= '0;
            idx         <= '0;
            eq_acc      <= 1'b0;
            gt_acc      <= 1'b0;
            res_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_l    <= a;
                        b_l    <= b;
                        idx    <= IW'(N - 1);
                        eq_acc <= 1'b1;
                        gt_acc <= 1'b0;
                    end
                end
                RUN: begin
                    eq_acc <= eq_o;
                    gt_acc <= gt_o;
                    if (last) begin
                        res_valid_q <= 1'b1;
                        eq_q        <= eq_o;
                        gt_q        <= gt_o;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs depend on state only, never on inputs
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = res_valid_q;
    assign EQ          = eq_q;
    assign GT          = gt_q;

endmodule
